// File: rtl/mult_8_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier built on multi_4.
// The shift table gives each nibble-pair product its weight in the 16-bit result.
package mult_8_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int         NIB_W     = 4;
  localparam int         OP_W      = 8;
  localparam int         P_W       = 16;
  localparam logic [1:0] LAST_STEP = 2'd3;

  // Step order: lo*lo, hi*lo, lo*hi, hi*hi.
  localparam logic [3:0] SHIFT_TAB [0:3] = '{4'd0, 4'd4, 4'd4, 4'd8};

  function automatic logic [3:0] step_shift(input logic [1:0] step);
    return SHIFT_TAB[step];
  endfunction

endpackage

// File: rtl/multi_4.sv
// Combinational 4x4 unsigned multiplier, shared datapath used by mult_8_seq.
module multi_4
  import mult_8_seq_pkg::*;
(
  input  logic [NIB_W-1:0]   a,
  input  logic [NIB_W-1:0]   b,
  output logic [2*NIB_W-1:0] p
);

  logic [2*NIB_W-1:0] pp_row [NIB_W];

  // One shifted copy of a per set bit of b.
  generate
    for (genvar gi = 0; gi < NIB_W; gi++) begin : g_row
      assign pp_row[gi] = b[gi] ? ({{NIB_W{1'b0}}, a} << gi) : '0;
    end
  endgenerate

  assign p = pp_row[0] + pp_row[1] + pp_row[2] + pp_row[3];

endmodule

// File: rtl/mult_8_seq.sv
// Sequential 8x8 unsigned multiplier: one multi_4 reused over four cycles with
// shift-accumulate, result registered in p with a one-cycle done pulse.
module mult_8_seq
  import mult_8_seq_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [P_W-1:0]  p
);

  state_t                state_reg;
  logic [1:0]            step_reg;
  logic [P_W-1:0]        acc_reg;
  logic [OP_W-1:0]       a_reg;
  logic [OP_W-1:0]       b_reg;
  logic [P_W-1:0]        p_reg;
  logic                  ready_reg;
  logic                  busy_reg;
  logic                  done_reg;

  logic [NIB_W-1:0]      mul_a;
  logic [NIB_W-1:0]      mul_b;
  logic [2*NIB_W-1:0]    pp;
  logic [P_W-1:0]        acc_next;
  logic                  accept;

  multi_4 u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (pp)
  );

  // step[0] picks the high nibble of a, step[1] the high nibble of b.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state_reg == ST_MUL) begin
      mul_a = step_reg[0] ? a_reg[7:4] : a_reg[3:0];
      mul_b = step_reg[1] ? b_reg[7:4] : b_reg[3:0];
    end
  end

  assign acc_next = acc_reg + ({{(P_W-2*NIB_W){1'b0}}, pp} << step_shift(step_reg));
  assign accept   = start && ready_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      step_reg  <= '0;
      acc_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      p_reg     <= '0;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            acc_reg   <= '0;
            step_reg  <= '0;
            state_reg <= ST_MUL;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end else begin
            state_reg <= ST_IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end
        end
        ST_MUL: begin
          acc_reg <= acc_next;
          if (step_reg == LAST_STEP) begin
            p_reg     <= acc_next;
            state_reg <= ST_DONE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            step_reg <= step_reg + 2'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign p     = p_reg;

endmodule

// File: tb/tb_mult_8_seq.sv
// Bench for mult_8_seq: directed corner cases plus random operands against a*b.
module tb_mult_8_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] p;

  int n_vec;
  int n_err;

  mult_8_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the product is simply the arithmetic product.
  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    return 16'(int'(x) * int'(y));
  endfunction

  // Full transaction: accept, wait for done (bounded), check latency, busy width, p, pulse.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb);
    int lat;
    int busy_cnt;
    lat = 0;
    busy_cnt = 0;
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
      if (busy) busy_cnt++;
    end
    check_value("latency", lat, 4);
    check_value("busy_cycles", busy_cnt, 4);
    check_value("product", p, ref_mul(ta, tb));
    $display("op a=%02h b=%02h p=%04h lat=%0d", ta, tb, p, lat);
    @(posedge clk); #1;
    check_value("done_pulse", done, 0);
  endtask

  initial begin
    int first_gap;
    int done_cnt;
    logic held_ok;
    n_vec = 0;
    n_err = 0;
    start = 1'b0;
    a = '0;
    b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_ready", ready, 1);
    check_value("rst_busy", busy, 0);
    check_value("rst_done", done, 0);
    check_value("rst_p", p, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operands, including extremes.
    do_op(8'h12, 8'h34);
    do_op(8'hFF, 8'hFF);
    do_op(8'h80, 8'h08);
    do_op(8'h00, 8'hAB);

    // Back-to-back: start held during DONE.
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_value("b2b_first_done", done, 1);
    check_value("b2b_first_p", p, ref_mul(8'h12, 8'h34));
    $display("op a=12 b=34 p=%04h (first of pair)", p);
    @(negedge clk);
    a = 8'h0F; b = 8'h10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_value("b2b_accept_busy", busy, 1);
    first_gap = 0;
    held_ok = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if (!done && p !== ref_mul(8'h12, 8'h34)) held_ok = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        first_gap = c + 1;
        break;
      end
    end
    check_value("b2b_p_held", held_ok, 1);
    check_value("b2b_gap", first_gap, 5);
    check_value("b2b_second_p", p, ref_mul(8'h0F, 8'h10));
    $display("op a=0f b=10 p=%04h gap=%0d", p, first_gap);
    @(posedge clk); #1;

    // Start during MUL must be ignored.
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    check_value("ignore_done_cnt", done_cnt, 1);
    check_value("ignore_p", p, ref_mul(8'h12, 8'h34));
    $display("op a=12 b=34 with stray start p=%04h dones=%0d", p, done_cnt);

    // Asynchronous reset during the third multiply step.
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_value("arst_p", p, 0);
    check_value("arst_done", done, 0);
    check_value("arst_ready", ready, 1);
    check_value("arst_busy", busy, 0);
    $display("reset mid-multiply p=%04h ready=%0b", p, ready);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h05, 8'h07);

    // Random operands with random idle gaps.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_op(ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
